// File: rtl/bk_pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// bk_pipelined_subtractor
//   Three-stage pipelined Brent-Kung prefix subtractor.
//   It computes diff = a - b - bin as a + ~b + ~bin, using a prefix
//   generate/propagate tree.
//     Stage 1 (_p1) : bit generate/propagate, carry-in c0 = ~bin.
//     Stage 2 (_p2) : up-sweep group generate/propagate.
//     Stage 3 (_p3) : down-sweep prefix carries, difference, borrow, overflow.
//   One operand pair per cycle over valid/ready. All stages advance together
//   when the output register is empty or being drained.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valids and outputs)
//   in_valid   operand pair {a,b,bin} valid
//   in_ready   pair accepted this cycle (combinational from out_ready/state)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow in
//   out_valid  diff/bout/ovf valid
//   out_ready  consumer accepts result this cycle
//   diff       (a - b - bin) mod 2**WIDTH
//   bout       borrow out, 1 iff a < b + bin (unsigned)
//   ovf        two's-complement overflow of the subtraction
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module bk_pipelined_subtractor #(
   parameter int WIDTH  = 32,
   parameter int LEVELS = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   logic             adv;

   logic             vld_p1_q, vld_p2_q, vld_p3_q;

   logic [WIDTH-1:0] g_d, p_d;
   logic [WIDTH-1:0] g_p1_q, p_p1_q;
   logic             c0_p1_q, am_p1_q, bm_p1_q;

   logic [WIDTH-1:0] gt_d, pt_d;
   logic [WIDTH-1:0] gt_p2_q, pt_p2_q, p_p2_q;
   logic             c0_p2_q, am_p2_q, bm_p2_q;

   logic [WIDTH-1:0] gpre, ppre;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] diff_d;
   logic             bout_d, ovf_d;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q, ovf_q;

   // The whole pipeline moves as one; a full output register that is not
   // being drained freezes every stage, bubbles included.
   assign adv       = ~vld_p3_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_p3_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;

   // ---- stage 1: bit generate / propagate of a + ~b ----
   assign g_d = a & ~b;
   assign p_d = a ^ ~b;

   always_ff @(posedge clk) begin
      if (adv) begin
         g_p1_q  <= g_d;
         p_p1_q  <= p_d;
         c0_p1_q <= ~bin;
         am_p1_q <= a[WIDTH-1];
         bm_p1_q <= b[WIDTH-1];
      end
   end

   // ---- stage 2: up-sweep ----
   // Tree level k-1 (block k): node i with i mod 2**k == 2**k-1 absorbs
   // node i-2**(k-1); every other node passes through.
   for (genvar k = 0; k <= LEVELS; k++) begin : g_up
      logic [WIDTH-1:0] gg, pp;
      if (k == 0) begin : g_base
         assign gg = g_p1_q;
         assign pp = p_p1_q;
      end else begin : g_lvl
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i % (2**k)) == (2**k) - 1) begin : g_op
               assign gg[i] = g_up[k-1].gg[i]
                            | (g_up[k-1].pp[i] & g_up[k-1].gg[i - 2**(k-1)]);
               assign pp[i] = g_up[k-1].pp[i] & g_up[k-1].pp[i - 2**(k-1)];
            end else begin : g_pass
               assign gg[i] = g_up[k-1].gg[i];
               assign pp[i] = g_up[k-1].pp[i];
            end
         end
      end
   end

   assign gt_d = g_up[LEVELS].gg;
   assign pt_d = g_up[LEVELS].pp;

   always_ff @(posedge clk) begin
      if (adv) begin
         gt_p2_q <= gt_d;
         pt_p2_q <= pt_d;
         p_p2_q  <= p_p1_q;
         c0_p2_q <= c0_p1_q;
         am_p2_q <= am_p1_q;
         bm_p2_q <= bm_p1_q;
      end
   end

   // ---- stage 3: down-sweep, difference and flags ----
   // Step j uses span K = LEVELS-1-j. Node i with i == 2**K-1 (mod 2**(K+1))
   // and i >= 2**(K+1) still holds only [i : i-2**K+1]; its left neighbour
   // i-2**K is already a full prefix, so one combine completes node i.
   for (genvar j = 0; j < LEVELS; j++) begin : g_dn
      logic [WIDTH-1:0] gg, pp;
      if (j == 0) begin : g_base
         assign gg = gt_p2_q;
         assign pp = pt_p2_q;
      end else begin : g_lvl
         localparam int K = LEVELS - 1 - j;
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= 2**(K+1)) && (((i + 1) % (2**(K+1))) == 2**K)) begin : g_op
               assign gg[i] = g_dn[j-1].gg[i]
                            | (g_dn[j-1].pp[i] & g_dn[j-1].gg[i - 2**K]);
               assign pp[i] = g_dn[j-1].pp[i] & g_dn[j-1].pp[i - 2**K];
            end else begin : g_pass
               assign gg[i] = g_dn[j-1].gg[i];
               assign pp[i] = g_dn[j-1].pp[i];
            end
         end
      end
   end

   assign gpre = g_dn[LEVELS-1].gg;
   assign ppre = g_dn[LEVELS-1].pp;

   // c[i+1] = G[i:0] | P[i:0] & c0 ; carry out is the inverted borrow.
   assign c      = {gpre | (ppre & {WIDTH{c0_p2_q}}), c0_p2_q};
   assign diff_d = p_p2_q ^ c[WIDTH-1:0];
   assign bout_d = ~c[WIDTH];
   assign ovf_d  = (am_p2_q != bm_p2_q) & (diff_d[WIDTH-1] != am_p2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
      end else if (adv) begin
         vld_p1_q <= in_valid;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
      end
   end

   // Output registers only take real results so a bubble never disturbs them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (adv && vld_p2_q) begin
         diff_q <= diff_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_bk_pipelined_subtractor.sv
`timescale 1ns/1ps
module tb_bk_pipelined_subtractor;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bk_pipelined_subtractor #(.WIDTH(W), .LEVELS(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      vec_t r;
      logic [W:0] t;
      t = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      r.a = ma; r.b = mb; r.bin = mbin;
      r.d = t[W-1:0];
      r.bo = t[W];
      r.ov = (ma[W-1] != mb[W-1]) && (r.d[W-1] != ma[W-1]);
      return r;
   endfunction

   // Single transaction with out_ready=1; checks acceptance, latency, result.
   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, W'(lat), 32'd3);
      chk({tag, "_diff"}, diff, v.d);
      chk1({tag, "_bout"}, bout, v.bo);
      chk1({tag, "_ovf"}, ovf, v.ov);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      logic [W-1:0] bp_a [3];
      logic [W-1:0] bp_b [3];
      logic [W-1:0] bp_d [3];
      logic         bp_bo[3];
      vec_t exp_q[$];
      vec_t e;
      int n, stale, pushed, cyc;

      vecs[0] = '{32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0};
      vecs[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0};
      vecs[2] = '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
      vecs[3] = '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1};
      vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1};
      vecs[5] = '{32'h1234_5678,  32'h0234_5678,  1'b0, 32'h1000_0000,  1'b0, 1'b0};
      vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
      vecs[7] = '{32'h0000_0000,  32'h8000_0000,  1'b0, 32'h8000_0000,  1'b1, 1'b1};
      vecs[8] = '{32'hAAAA_AAAA,  32'h5555_5555,  1'b1, 32'h5555_5554,  1'b0, 1'b1};

      bp_a[0] = 32'd10; bp_b[0] = 32'd4; bp_d[0] = 32'd6;         bp_bo[0] = 1'b0;
      bp_a[1] = 32'd9;  bp_b[1] = 32'd9; bp_d[1] = 32'd0;         bp_bo[1] = 1'b0;
      bp_a[2] = 32'd1;  bp_b[2] = 32'd2; bp_d[2] = 32'hFFFF_FFFF; bp_bo[2] = 1'b1;

      // Reset state, observed before any clock edge.
      #2;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_diff", diff, 32'd0);
      chk1("rst_bout", bout, 1'b0);
      chk1("rst_ovf", ovf, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: three pairs in, output stalled for five cycles.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = bp_a[i]; b = bp_b[i]; bin = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int s = 0; s < 5; s++) begin
         chk1($sformatf("bp_stall%0d_out_valid", s), out_valid, 1'b1);
         chk1($sformatf("bp_stall%0d_in_ready", s), in_ready, 1'b0);
         chk($sformatf("bp_stall%0d_diff", s), diff, 32'd6);
         chk1($sformatf("bp_stall%0d_bout", s), bout, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1;
      n = 0;
      for (int cy = 0; cy < 10; cy++) begin
         if (out_valid) begin
            if (n < 3) begin
               chk($sformatf("bp_res%0d_diff", n), diff, bp_d[n]);
               chk1($sformatf("bp_res%0d_bout", n), bout, bp_bo[n]);
            end
            n++;
         end
         step();
      end
      chk("bp_result_count", W'(n), 32'd3);

      // Reset with two pairs in flight.
      a = 32'd20; b = 32'd3; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd8; b = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      step();
      chk1("mid_pre_out_valid", out_valid, 1'b1);
      chk("mid_pre_diff", diff, 32'd17);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_diff", diff, 32'd0);
      chk1("mid_rst_bout", bout, 1'b0);
      #2;
      @(posedge clk); #1;
      rst_n = 1'b1;
      stale = 0;
      for (int cy = 0; cy < 5; cy++) begin
         if (out_valid) stale++;
         step();
      end
      chk("mid_stale_results", W'(stale), 32'd0);
      run_vec('{32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0}, "post_rst");

      // Random traffic with scoreboard.
      pushed = 0;
      cyc = 0;
      while (pushed < 10000 && cyc < 60000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         a = $urandom;
         b = $urandom;
         bin = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk1("rnd_unexpected_result", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("rnd_diff", diff, e.d);
               chk1("rnd_bout", bout, e.bo);
               chk1("rnd_ovf", ovf, e.ov);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, bin));
            pushed++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int cy = 0; cy < 20; cy++) begin
         #1;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk1("drain_unexpected_result", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("drain_diff", diff, e.d);
               chk1("drain_bout", bout, e.bo);
               chk1("drain_ovf", ovf, e.ov);
            end
         end
         @(posedge clk); #1;
      end
      chk("rnd_pushed", W'(pushed), 32'd10000);
      chk("rnd_leftover", W'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
